dmi_arbiter: RTL

Two-requester arbiter and sequencer for the Debug Module Interface (DMI). It sits between the DMI-side level handshake of the UART TAP (read/write held until done) plus one further DTM requester, and the valid/ready `dmi_req_t`/`dmi_resp_t` port of the debug module. It grants the DMI to one requester at a time with round-robin fairness and runs exactly one request/response transaction per grant. It returns the result in `dmi_req_t` layout with a one-cycle done pulse.

---
 rtl/dmi_arbiter_if.sv | 35 +++
 rtl/dmi_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter_if.sv
// dmi_arbiter_if: debug-module side of the DMI arbiter.
//
// Valid/ready semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. Once the source raises valid it
// keeps valid high and the payload constant until that edge; ready may be
// raised or lowered freely and never depends combinationally on valid.
//
// Signals:
//   req_valid  arbiter -> DM   request valid
//   req_ready  DM -> arbiter   DM accepts request
//   req        arbiter -> DM   {addr, data, op}
//   resp_valid DM -> arbiter   response valid
//   resp_ready arbiter -> DM   arbiter accepts response
//   resp       DM -> arbiter   {data, resp}
interface dmi_arbiter_if #(
    parameter int REQ_W  = 41,
    parameter int RESP_W = 34
);
    logic              req_valid;
    logic              req_ready;
    logic [REQ_W-1:0]  req;
    logic              resp_valid;
    logic              resp_ready;
    logic [RESP_W-1:0] resp;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp
    );
endinterface

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: grants the debug-module DMI port to one of two level-handshake
// requesters (index 0 = UART TAP, index 1 = second DTM) with round-robin
// fairness, runs one request/response per grant and returns the result with
// a one-cycle done pulse. All outputs are registered.
//
// Ports:
//   CLK_I, RST_NI  clock, asynchronous active-low reset
//   READ_I/WRITE_I per-requester request levels
//   DMI_I          per-requester request word {addr, data, op}; op ignored
//   DMI_O          per-requester result {captured addr, resp data, resp code}
//   DONE_O         per-requester completion pulse
//   GRANT_O        one-hot current owner, 0 when idle
//   STATE_O        FSM state for observation
//   dmi            DM-side request/response channels (master modport)
module dmi_arbiter #(
    parameter int REQ_W  = 41,
    parameter int RESP_W = 34
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic [1:0]            READ_I,
    input  logic [1:0]            WRITE_I,
    input  logic [1:0][REQ_W-1:0] DMI_I,
    output logic [1:0][REQ_W-1:0] DMI_O,
    output logic [1:0]            DONE_O,
    output logic [1:0]            GRANT_O,
    output logic [1:0]            STATE_O,
    dmi_arbiter_if.master         dmi
);
    localparam int ADDR_LSB = 34;
    localparam int DATA_LSB = 2;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_req  = 2'd1,
        st_resp = 2'd2,
        st_done = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              armed_q, armed_d;
    logic                    last_q, last_d;
    logic                    gidx_q, gidx_d;
    logic [1:0]              grant_q, grant_d;
    logic                    req_valid_q, req_valid_d;
    logic                    resp_ready_q, resp_ready_d;
    logic [REQ_W-1:0]        req_q, req_d;
    logic [1:0][REQ_W-1:0]   dmi_o_q, dmi_o_d;
    logic [1:0]              done_q, done_d;

    logic [1:0]              pending;
    logic                    pick_idx;

    // The op field of the incoming words is regenerated from READ_I/WRITE_I.
    logic unused_op;
    assign unused_op = ^{DMI_I[0][DATA_LSB-1:0], DMI_I[1][DATA_LSB-1:0]};

    assign pending = armed_q & (READ_I | WRITE_I);
    // On a tie the requester that was not granted last wins.
    assign pick_idx = (&pending) ? ~last_q : pending[1];

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        last_d       = last_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        req_valid_d  = req_valid_q;
        resp_ready_d = resp_ready_q;
        req_d        = req_q;
        dmi_o_d      = dmi_o_q;
        done_d       = '0;

        case (state_q)
            st_idle: begin
                if (|pending) begin
                    gidx_d                        = pick_idx;
                    grant_d                       = '0;
                    grant_d[pick_idx]             = 1'b1;
                    req_d[REQ_W-1:ADDR_LSB]       = DMI_I[pick_idx][REQ_W-1:ADDR_LSB];
                    // Write has priority when both levels are high.
                    if (WRITE_I[pick_idx]) begin
                        req_d[ADDR_LSB-1:DATA_LSB] = DMI_I[pick_idx][ADDR_LSB-1:DATA_LSB];
                        req_d[DATA_LSB-1:0]        = 2'b10;
                    end else begin
                        req_d[ADDR_LSB-1:DATA_LSB] = '0;
                        req_d[DATA_LSB-1:0]        = 2'b01;
                    end
                    req_valid_d = 1'b1;
                    state_d     = st_req;
                end
            end
            st_req: begin
                if (dmi.req_ready) begin
                    req_valid_d  = 1'b0;
                    resp_ready_d = 1'b1;
                    state_d      = st_resp;
                end
            end
            st_resp: begin
                if (dmi.resp_valid) begin
                    resp_ready_d     = 1'b0;
                    dmi_o_d[gidx_q]  = {req_q[REQ_W-1:ADDR_LSB], dmi.resp};
                    done_d[gidx_q]   = 1'b1;
                    state_d          = st_done;
                end
            end
            st_done: begin
                armed_d[gidx_q] = 1'b0;
                last_d          = gidx_q;
                grant_d         = '0;
                state_d         = st_idle;
            end
            default: state_d = st_idle;
        endcase

        // A low level re-arms the requester; this wins over the done-cycle
        // clear so a requester that already withdrew is not left disarmed.
        armed_d = armed_d | ~(READ_I | WRITE_I);
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q      <= st_idle;
            armed_q      <= 2'b11;
            last_q       <= 1'b1;
            gidx_q       <= 1'b0;
            grant_q      <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            req_q        <= '0;
            dmi_o_q      <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            last_q       <= last_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            req_q        <= req_d;
            dmi_o_q      <= dmi_o_d;
            done_q       <= done_d;
        end
    end

    assign DMI_O          = dmi_o_q;
    assign DONE_O         = done_q;
    assign GRANT_O        = grant_q;
    assign STATE_O        = state_q;
    assign dmi.req_valid  = req_valid_q;
    assign dmi.req        = req_q;
    assign dmi.resp_ready = resp_ready_q;
endmodule
